sample_framer: RTL and testbench
================================

Name: sample_framer

Overview:
- Upstream stage feeding the second-largest tracker.
- Accepts a valid/ready sample stream and buffers it in a small FIFO.
- Emits samples one per cycle in fixed-length frames, marked with start-of-frame and end-of-frame.
- Inserts a programmable idle gap between frames and pulses a clear strobe so the downstream tracker can restart per frame.

Parameters:
- DATA_WIDTH, 2: sample width in bits.
- DEPTH, 4: FIFO entries; power of two, >=2.
- FRAME_LEN, 4: samples per frame; >=1.
- GAP_CYCLES, 2: idle cycles between frames; 0 allowed.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  framing enable.
- in_valid  in  1  input sample valid.
- in_data  in  DATA_WIDTH  input sample.
- in_ready  out  1  FIFO can accept a sample.
- out_valid  out  1  output sample valid.
- out_data  out  DATA_WIDTH  output sample (FIFO head).
- out_ready  in  1  downstream accepts a sample.
- out_sof  out  1  current output is the first sample of a frame.
- out_eof  out  1  current output is the last sample of a frame.
- frame_clr  out  1  one-cycle pulse after each frame completes.

Behaviour:
- Reset: one clock, one reset; rst is synchronous and active-high. While rst=1 at the clock edge:
  - FIFO emptied, sample index=0, state=IDLE.
  - out_valid, out_sof, out_eof, frame_clr = 0; out_data = 0.
  - in_ready = 0 during the reset cycle and 1 on the first cycle after.
- Reset mid-frame discards buffered data and the partial frame. Any handshake in that cycle is ignored.
- FIFO:
  - in_ready = !full.
  - Write occurs on in_valid && in_ready.
  - No write-through when full: in_ready stays 0 even if a pop occurs in the same cycle.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop when non-full and non-empty leaves the count unchanged.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Latency: a sample written at edge N is presentable on out_data at the earliest in the cycle after N (minimum 1 cycle). There is no bypass when empty.
- States:
  - IDLE: out_valid=0. Go to STREAM when en=1. The FIFO still accepts input while IDLE.
  - STREAM:
    - out_valid = !empty; out_data = head.
    - Sample index idx counts 0..FRAME_LEN-1.
    - out_sof = out_valid && idx==0; out_eof = out_valid && idx==FRAME_LEN-1. If FRAME_LEN=1, both are asserted together.
    - idx increments on pop only; out_valid/out_data stay stable while out_ready=0.
    - On pop with out_eof: idx returns to 0 and the next state is:
      - GAP, if GAP_CYCLES>0;
      - otherwise IDLE, if en=0;
      - otherwise STREAM.
  - GAP:
    - out_valid=0; gap counter runs GAP_CYCLES cycles.
    - Exit to STREAM if en=1, else IDLE.
- frame_clr: asserted for exactly one cycle, the cycle immediately after the eof pop, regardless of GAP_CYCLES.
- en deasserted mid-frame: the current frame completes normally; IDLE is entered after eof (and after GAP, if any). en is sampled only in IDLE and at frame/gap end.
- Empty mid-frame: out_valid drops and idx holds. The frame resumes when data arrives; there is no timeout.

Optional Feature:
- Macro SAMPLE_FRAMER_FRAME_CNT_EN.
- When defined:
  - Adds output port frames_done, 16 bits.
  - Reset value 0; increments by 1 on each eof pop; wraps 0xFFFF->0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package sample_framer_pkg holds:
  - the state enum typedef (IDLE, STREAM, GAP);
  - localparam helpers for pointer, count and gap-counter widths.
- One natural sub-module: sync_fifo (parameters DATA_WIDTH, DEPTH; ports push/pop/full/empty/head), instantiated once.
- Framing FSM and counters stay in the top module.

Test Plan (DATA_WIDTH=2, DEPTH=4, FRAME_LEN=4, GAP_CYCLES=2):
- Reset, en=1, push 3,1,2,0 back-to-back with out_ready=1 -> out_data 3,1,2,0 on consecutive cycles starting 1 cycle after the first push; out_sof on 3, out_eof on 0; frame_clr pulses the next cycle; out_valid=0 for 2 gap cycles.
- out_ready=0, push 5 samples -> in_ready falls after 4 accepted; the 5th is held by the source. Raise out_ready -> all 5 emerge in order; the 5th carries out_sof of frame 2.
- FIFO full, assert out_ready and in_valid in the same cycle -> pop occurs, no push. in_ready returns 1 the next cycle.
- Drop en after the 2nd sample of a frame -> samples 3 and 4 still output with out_eof on the 4th; after the gap, state is IDLE and out_valid=0 despite data in the FIFO. Re-raise en -> streaming resumes with out_sof.
- Assert rst mid-frame with 2 samples buffered -> next cycle out_valid=0 and in_ready=1. After re-enable, the next output sample carries out_sof.
- With SAMPLE_FRAMER_FRAME_CNT_EN, stream 3 full frames -> frames_done reads 3; with rst it returns to 0.

Source files
------------

// File: rtl/sample_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_framer_pkg
// Purpose  : Shared state encoding and width helpers for the sample framer.
// Revision : 1.0 - initial release
// ============================================================================
package sample_framer_pkg;

    // Framing state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    // Width of the frame counter exposed when frame counting is built in
    localparam int FRAME_CNT_W = 16;

    // FIFO pointer width; DEPTH is a power of two so pointers wrap naturally
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // FIFO occupancy width: one extra bit so a full FIFO is representable
    function automatic int cnt_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

    // Sample index width, counts 0..frame_len-1
    function automatic int idx_width(input int frame_len);
        return (frame_len <= 1) ? 1 : $clog2(frame_len);
    endfunction

    // Gap counter width, counts 0..gap_cycles-1 (kept at 1 bit when unused)
    function automatic int gap_width(input int gap_cycles);
        return (gap_cycles <= 1) ? 1 : $clog2(gap_cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with registered pointers and occupancy count.
//            Head is shown combinationally; no write-through when full and
//            no bypass when empty.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sample_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO refuses writes even when a pop happens in the same cycle
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_framer.sv
`default_nettype none
// ============================================================================
// Module   : sample_framer
// Purpose  : Buffers a valid/ready sample stream and emits it in fixed-length
//            frames with sof/eof marks, an idle gap between frames and a
//            one-cycle frame_clr strobe after each frame.
//            Optional: define SAMPLE_FRAMER_FRAME_CNT_EN to add the 16-bit
//            frames_done counter output.
// Revision : 1.0 - initial release
// ============================================================================
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int FRAME_LEN  = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  frame_clr
`ifdef SAMPLE_FRAMER_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frames_done
`endif
);

    localparam int IDX_W = idx_width(FRAME_LEN);
    localparam int GAP_W = gap_width(GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [GAP_W-1:0] gap_q;
    logic             frame_clr_q;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_idx_last;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i (in_data),
        .pop_i   (w_pop),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .head_o  (w_fifo_head)
    );

    // Handshakes are masked while rst is high so nothing moves in that cycle
    assign in_ready   = !w_fifo_full && !rst;
    assign w_push     = in_valid && in_ready;
    assign out_valid  = (state_q == ST_STREAM) && !w_fifo_empty && !rst;
    assign out_data   = out_valid ? w_fifo_head : '0;
    assign w_idx_last = (idx_q == IDX_LAST);
    assign out_sof    = out_valid && (idx_q == '0);
    assign out_eof    = out_valid && w_idx_last;
    assign w_pop      = out_valid && out_ready;
    assign frame_clr  = frame_clr_q;

    // Framing FSM: sample index, gap timing and the post-frame clear strobe.
    // en is only looked at in IDLE and at frame/gap end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            frame_clr_q <= 1'b0;
        end else begin
            frame_clr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_pop) begin
                        if (w_idx_last) begin
                            idx_q       <= '0;
                            frame_clr_q <= 1'b1;
                            if (GAP_CYCLES > 0) begin
                                gap_q   <= '0;
                                state_q <= ST_GAP;
                            end else begin
                                state_q <= en ? ST_STREAM : ST_IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= en ? ST_STREAM : ST_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SAMPLE_FRAMER_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frames_done_q;

    assign frames_done = frames_done_q;

    // Completed-frame counter, wraps naturally at its width
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_done_q <= '0;
        end else if (w_pop && w_idx_last) begin
            frames_done_q <= frames_done_q + FRAME_CNT_W'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_framer
// Purpose  : Self-checking bench for sample_framer (DATA_WIDTH=2, DEPTH=4,
//            FRAME_LEN=4, GAP_CYCLES=2). Accepted inputs are pushed to an
//            expectation queue with their frame position; emitted samples
//            are popped and compared. Scenario tasks add inline checks.
//            Define SAMPLE_FRAMER_FRAME_CNT_EN to also test frames_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_framer;

    localparam int FL = 4;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [1:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_data = 2'd0;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_ready = 1'b0;
    logic       out_sof;
    logic       out_eof;
    logic       frame_clr;
`ifdef SAMPLE_FRAMER_FRAME_CNT_EN
    logic [15:0] frames_done;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   pos = 0;
    logic clr_exp = 1'b0;

    sample_framer #(
        .DATA_WIDTH (2),
        .DEPTH      (4),
        .FRAME_LEN  (FL),
        .GAP_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .frame_clr (frame_clr)
`ifdef SAMPLE_FRAMER_FRAME_CNT_EN
        ,
        .frames_done (frames_done)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: compare pops, model frame_clr, record accepted pushes
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            pos     = 0;
            clr_exp = 1'b0;
        end else begin
            checks++;
            if (frame_clr !== clr_exp) begin
                errors++;
                $display("FAIL frame_clr got %b want %b at %0t", frame_clr, clr_exp, $time);
            end
            clr_exp = 1'b0;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got data %0d sof %b eof %b, want no output at %0t",
                             out_data, out_sof, out_eof, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_sof !== e.sof || out_eof !== e.eof) begin
                        errors++;
                        $display("FAIL sb_sample got data %0d sof %b eof %b want data %0d sof %b eof %b at %0t",
                                 out_data, out_sof, out_eof, e.data, e.sof, e.eof, $time);
                    end
                    clr_exp = e.eof;
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                e.data = in_data;
                e.sof  = (pos == 0);
                e.eof  = (pos == FL - 1);
                exp_q.push_back(e);
                pos = (pos + 1) % FL;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d samples left want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 2'd0 ||
            out_sof !== 1'b0 || out_eof !== 1'b0 || frame_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rdy %b vld %b data %0d sof %b eof %b clr %b want all 0",
                     in_ready, out_valid, out_data, out_sof, out_eof, frame_clr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy %b vld %b want rdy 1 vld 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic_frame();
        logic [1:0] v [4];
        v[0] = 2'd3; v[1] = 2'd1; v[2] = 2'd2; v[3] = 2'd0;
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            @(posedge clk); #2;
            checks++;
            if (out_valid !== 1'b1 || out_data !== v[i] ||
                out_sof !== (i == 0) || out_eof !== (i == 3)) begin
                errors++;
                $display("FAIL basic_out%0d got vld %b data %0d sof %b eof %b want vld 1 data %0d sof %b eof %b",
                         i, out_valid, out_data, out_sof, out_eof, v[i], (i == 0), (i == 3));
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (frame_clr !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_gap1 got clr %b vld %b want clr 1 vld 0", frame_clr, out_valid);
        end
        @(posedge clk); #2;
        checks++;
        if (frame_clr !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_gap2 got clr %b vld %b want clr 0 vld 0", frame_clr, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] d [4];
        d[0] = 2'd1; d[1] = 2'd2; d[2] = 2'd3; d[3] = 2'd0;
        @(posedge clk); #2;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            @(posedge clk); #2;
        end
        in_data = 2'd2;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== d[0] || out_sof !== 1'b1) begin
                errors++;
                $display("FAIL bp_full%0d got rdy %b vld %b data %0d sof %b want rdy 0 vld 1 data %0d sof 1",
                         c, in_ready, out_valid, out_data, out_sof, d[0]);
            end
            if (c == 0) begin
                @(posedge clk); #2;
            end
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_same got rdy %b want 0", in_ready);
        end
        @(posedge clk); #2;
        checks++;
        if (in_ready !== 1'b1 || out_data !== 2'd2) begin
            errors++;
            $display("FAIL fullpop_next got rdy %b data %0d want rdy 1 data 2", in_ready, out_data);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
        drain("fullpop");
    endtask

    task automatic test_en_drop();
        logic [1:0] v [6];
        v[0] = 2'd2; v[1] = 2'd3; v[2] = 2'd0; v[3] = 2'd1; v[4] = 2'd3; v[5] = 2'd2;
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            @(posedge clk); #2;
            if (i == 1) en = 1'b0;
            if (i == 3) begin
                checks++;
                if (out_eof !== 1'b1 || out_data !== v[3]) begin
                    errors++;
                    $display("FAIL endrop_eof got eof %b data %0d want eof 1 data %0d", out_eof, out_data, v[3]);
                end
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL endrop_idle%0d got vld %b want 0", c, out_valid);
            end
        end
        en = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_data !== v[4]) begin
            errors++;
            $display("FAIL endrop_resume got vld %b sof %b data %0d want vld 1 sof 1 data %0d",
                     out_valid, out_sof, out_data, v[4]);
        end
        drain("endrop");
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 2'd1;
        @(posedge clk); #2;
        in_data = 2'd2;
        @(posedge clk); #2;
        rst = 1'b1;
        in_data = 2'd3;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_during got rdy %b vld %b want rdy 0 vld 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after got vld %b rdy %b want vld 0 rdy 1", out_valid, in_ready);
        end
        in_valid = 1'b1; in_data = 2'd3;
        @(posedge clk); #2;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_data !== 2'd3) begin
            errors++;
            $display("FAIL rstmid_sof got vld %b sof %b data %0d want vld 1 sof 1 data 3",
                     out_valid, out_sof, out_data);
        end
        drain("rstmid");
    endtask

`ifdef SAMPLE_FRAMER_FRAME_CNT_EN
    task automatic test_frame_cnt();
        do_reset();
        checks++;
        if (frames_done !== 16'd0) begin
            errors++;
            $display("FAIL fcnt_reset got %0d want 0", frames_done);
        end
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3 * FL; i++) begin
            in_valid = 1'b1;
            in_data  = 2'(i);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        drain("fcnt");
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (frames_done !== 16'd3) begin
            errors++;
            $display("FAIL fcnt_three got %0d want 3", frames_done);
        end
        do_reset();
        checks++;
        if (frames_done !== 16'd0) begin
            errors++;
            $display("FAIL fcnt_clear got %0d want 0", frames_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_full_pop();
        test_en_drop();
        test_reset_midframe();
`ifdef SAMPLE_FRAMER_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
